// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder: CPU command
//               codes, responder FSM state encoding and wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Command codes presented by the CPU on cmd_memory
    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Read wait counter width (RD_WAIT is limited to 0..7)
    localparam int CNT_W = 3;

    // Responder FSM states; ST_CLEAR is only reachable when the clear feature is built
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_CLEAR    = 2'd3
    } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x 8 data RAM with one synchronous write port and one
//               registered read port. Array contents are never reset; only
//               the read data register is.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, captured only when the parent requests a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_memory_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_resp
// Description : Responder end of the CPU data-memory interface. Decodes the
//               command/address, writes the RAM in one edge, sequences reads
//               with RD_WAIT wait cycles and drives the shared data bus only
//               during the single read-response cycle.
//               Optional build macro DMEM_CLEAR_EN: zero the whole RAM after
//               reset (one word per cycle) before accepting commands.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_memory,
    input  logic [7:0] addr_memory,
    inout  wire  [7:0] data_memory,
    output logic       mem_busy,
    output logic       rd_valid,
    output logic       cmd_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_wait_load = (RD_WAIT > 0) ? CNT_W'(RD_WAIT - 1) : '0;

`ifdef DMEM_CLEAR_EN
    localparam state_t            c_reset_state = ST_CLEAR;
    localparam logic [AW-1:0]     c_last_addr   = AW'(DEPTH - 1);
`else
    localparam state_t            c_reset_state = ST_IDLE;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_addr;
    logic             r_oor;
    logic             r_oe;
    logic             r_err;
`ifdef DMEM_CLEAR_EN
    logic [AW-1:0]    r_clr_addr;
`endif

    logic             w_in_range;
    logic             w_cmd_write;
    logic             w_ram_we;
    logic [AW-1:0]    w_ram_waddr;
    logic [7:0]       w_ram_wdata;
    logic             w_ram_re;
    logic [7:0]       w_ram_rdata;
    logic [7:0]       w_rd_out;

    // Range check is done on the full 8-bit address so truncated RAM indices never alias
    assign w_in_range  = ({1'b0, addr_memory} < 9'(DEPTH));
    assign w_cmd_write = (r_state == ST_IDLE) && (cmd_memory == CMD_WRITE) && w_in_range;

    // The RAM word is fetched in the first RD_DRIVE cycle and presented in the second
    assign w_ram_re = (r_state == ST_RD_DRIVE) && !r_oe && !r_oor;

`ifdef DMEM_CLEAR_EN
    // Clear sweep and CPU writes share the single write port; they never overlap in time
    always_comb begin
        w_ram_we    = w_cmd_write;
        w_ram_waddr = addr_memory[AW-1:0];
        w_ram_wdata = data_memory;
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_clr_addr;
            w_ram_wdata = 8'h00;
        end
    end
`else
    // Only CPU writes reach the RAM write port
    always_comb begin
        w_ram_we    = w_cmd_write;
        w_ram_waddr = addr_memory[AW-1:0];
        w_ram_wdata = data_memory;
    end
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_addr),
        .o_rdata (w_ram_rdata)
    );

    // Responder FSM: command decode, wait sequencing, bus enable and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_reset_state;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_oor   <= 1'b0;
            r_oe    <= 1'b0;
            r_err   <= 1'b0;
`ifdef DMEM_CLEAR_EN
            r_clr_addr <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (cmd_memory)
                        CMD_IDLE: begin
                            r_err <= 1'b0;
                        end
                        CMD_WRITE: begin
                            // In-range writes go straight to the RAM port
                            r_err <= !w_in_range;
                        end
                        CMD_READ: begin
                            r_addr  <= addr_memory[AW-1:0];
                            r_oor   <= !w_in_range;
                            r_err   <= !w_in_range;
                            r_cnt   <= c_wait_load;
                            r_state <= (RD_WAIT == 0) ? ST_RD_DRIVE : ST_RD_WAIT;
                        end
                        default: begin
                            r_err <= 1'b1;
                        end
                    endcase
                end
                ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RD_DRIVE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RD_DRIVE: begin
                    // First edge turns the bus on, second edge releases it and returns to IDLE
                    if (!r_oe) begin
                        r_oe <= 1'b1;
                    end else begin
                        r_oe    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if (r_clr_addr == c_last_addr) begin
                        r_state <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Out-of-range reads complete normally but present zero
    assign w_rd_out    = r_oor ? 8'h00 : w_ram_rdata;
    assign data_memory = r_oe ? w_rd_out : 8'hzz;
    assign rd_valid    = r_oe;
    assign cmd_err     = r_err;
    assign mem_busy    = (r_state != ST_IDLE);

endmodule : data_memory_resp
`default_nettype wire

// File: tb/tb_data_memory_resp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_memory_resp
// Description : Self-checking bench for data_memory_resp. Three instances:
//               0: DEPTH=256 RD_WAIT=1, 1: DEPTH=128 RD_WAIT=0,
//               2: DEPTH=16  RD_WAIT=7.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_resp;

`ifdef DMEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0][7:0] cmd;
    logic [2:0][7:0] addr;
    logic [2:0][7:0] drv;
    logic [2:0]      den;
    logic [2:0]      busy;
    logic [2:0]      vld;
    logic [2:0]      err;
    wire  [7:0]      bus0;
    wire  [7:0]      bus1;
    wire  [7:0]      bus2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         d;
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int         d;
        logic [7:0] data;
        int         lat;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    assign bus0 = den[0] ? drv[0] : 8'hzz;
    assign bus1 = den[1] ? drv[1] : 8'hzz;
    assign bus2 = den[2] ? drv[2] : 8'hzz;

    data_memory_resp #(.DEPTH(256), .RD_WAIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_memory(cmd[0]), .addr_memory(addr[0]),
        .data_memory(bus0), .mem_busy(busy[0]), .rd_valid(vld[0]), .cmd_err(err[0])
    );
    data_memory_resp #(.DEPTH(128), .RD_WAIT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_memory(cmd[1]), .addr_memory(addr[1]),
        .data_memory(bus1), .mem_busy(busy[1]), .rd_valid(vld[1]), .cmd_err(err[1])
    );
    data_memory_resp #(.DEPTH(16), .RD_WAIT(7)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_memory(cmd[2]), .addr_memory(addr[2]),
        .data_memory(bus2), .mem_busy(busy[2]), .rd_valid(vld[2]), .cmd_err(err[2])
    );

    function automatic int rdw(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 7;
        endcase
    endfunction

    function automatic logic [7:0] bus(input int d);
        case (d)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic vec_t mk(input int d, input logic [7:0] c, input logic [7:0] a,
                                input logic [7:0] w, input logic [7:0] ed, input logic ee);
        vec_t v;
        v.d = d; v.cmd = c; v.addr = a; v.wdata = w; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus released: a bench-driven pattern must be readable unchanged
    task automatic chk_release(input int d, input string name);
        drv[d] = 8'h5A;
        den[d] = 1'b1;
        #1;
        chk(name, bus(d), 8'h5A);
        den[d] = 1'b0;
    endtask

    task automatic wait_read(input int d, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!vld[d] && lat < 24) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("rd_valid_seen", vld[d], 1);
        if (vld[d]) begin
            chk("rd_latency", lat, e.lat);
            chk("rd_data", bus(d), e.data);
        end
        @(negedge clk);
        chk("rd_valid_one_cycle", vld[d], 0);
        chk("busy_after_read", busy[d], 0);
        chk_release(d, "bus_release_after_read");
    endtask

    task automatic run_vec(input vec_t x);
        @(negedge clk);
        cmd[x.d]  = x.cmd;
        addr[x.d] = x.addr;
        if (x.cmd == 8'h02) begin
            drv[x.d] = x.wdata;
            den[x.d] = 1'b1;
        end
        if (x.cmd == 8'h01) begin
            exp_t e;
            e.d = x.d; e.data = x.exp_data; e.lat = rdw(x.d) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd[x.d] = 8'h00;
        den[x.d] = 1'b0;
        chk("cmd_err", err[x.d], x.exp_err);
        if (x.cmd == 8'h01) begin
            wait_read(x.d, 0);
        end else begin
            chk("busy_non_read", busy[x.d], 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != 3'b000 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle_after_reset", busy, 3'b000);
    endtask

    task automatic watch_no_valid(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (vld != 3'b000) seen++;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        cmd = '0; addr = '0; drv = '0; den = '0;

        // Reset while the bus is idle
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, CLR ? 3'b111 : 3'b000);
        chk("rst_rd_valid", vld, 3'b000);
        chk("rst_cmd_err", err, 3'b000);
        chk_release(0, "rst_bus_release");
        rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        begin
            int cnt;
            int bad;
            cnt = 0; bad = 0;
            for (int n = 0; n < 40; n++) begin
                if (n == 2) begin cmd[2] = 8'h01; addr[2] = 8'h05; end
                if (n == 3) cmd[2] = 8'h00;
                if (busy[2]) cnt++;
                if (vld[2] || err[2]) bad++;
                @(negedge clk);
            end
            chk("clear_busy_cycles", cnt, 16);
            chk("clear_cmd_ignored", bad, 0);
            wait_idle();
            run_vec(mk(2, 8'h01, 8'h05, 8'h00, 8'h00, 1'b0));
        end
`endif
        wait_idle();

        // Vector table: {dut, cmd, addr, wdata, expected read data, expected cmd_err}
        vt.push_back(mk(0, 8'h02, 8'h10, 8'hA5, 8'h00, 1'b0));
        vt.push_back(mk(0, 8'h01, 8'h10, 8'h00, 8'hA5, 1'b0));
        vt.push_back(mk(0, 8'h02, 8'h11, 8'h5A, 8'h00, 1'b0));
        vt.push_back(mk(0, 8'h01, 8'h11, 8'h00, 8'h5A, 1'b0));
        vt.push_back(mk(0, 8'h01, 8'h10, 8'h00, 8'hA5, 1'b0));
        vt.push_back(mk(0, 8'h02, 8'hFF, 8'hC3, 8'h00, 1'b0));
        vt.push_back(mk(0, 8'h01, 8'hFF, 8'h00, 8'hC3, 1'b0));
        vt.push_back(mk(1, 8'h02, 8'h03, 8'h3C, 8'h00, 1'b0));
        vt.push_back(mk(1, 8'h01, 8'h03, 8'h00, 8'h3C, 1'b0));
        vt.push_back(mk(2, 8'h02, 8'h03, 8'h3C, 8'h00, 1'b0));
        vt.push_back(mk(2, 8'h01, 8'h03, 8'h00, 8'h3C, 1'b0));
        vt.push_back(mk(1, 8'h02, 8'h70, 8'h12, 8'h00, 1'b0));
        vt.push_back(mk(1, 8'h07, 8'h03, 8'hEE, 8'h00, 1'b1));
        vt.push_back(mk(1, 8'h02, 8'hF0, 8'h77, 8'h00, 1'b1));
        vt.push_back(mk(1, 8'h01, 8'hF0, 8'h00, 8'h00, 1'b1));
        vt.push_back(mk(1, 8'h01, 8'h70, 8'h00, 8'h12, 1'b0));
        vt.push_back(mk(1, 8'h01, 8'h03, 8'h00, 8'h3C, 1'b0));
        vt.push_back(mk(1, 8'h02, 8'h7F, 8'h81, 8'h00, 1'b0));
        vt.push_back(mk(1, 8'h01, 8'h7F, 8'h00, 8'h81, 1'b0));
        vt.push_back(mk(1, 8'h01, 8'h80, 8'h00, 8'h00, 1'b1));
        vt.push_back(mk(2, 8'h02, 8'h0F, 8'hE1, 8'h00, 1'b0));
        vt.push_back(mk(2, 8'h01, 8'h0F, 8'h00, 8'hE1, 1'b0));
        vt.push_back(mk(2, 8'h01, 8'h10, 8'h00, 8'h00, 1'b1));
        foreach (vt[i]) run_vec(vt[i]);

        // Write presented while a long read is in flight must be ignored
        @(negedge clk);
        cmd[2] = 8'h01; addr[2] = 8'h03;
        begin
            exp_t e;
            e.d = 2; e.data = 8'h3C; e.lat = 8;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("busy_during_wait", busy[2], 1);
        cmd[2] = 8'h02; addr[2] = 8'h03; drv[2] = 8'h99; den[2] = 1'b1;
        @(negedge clk);
        cmd[2] = 8'h00; den[2] = 1'b0;
        chk("no_err_busy_write", err[2], 0);
        wait_read(2, 1);
        run_vec(mk(2, 8'h01, 8'h03, 8'h00, 8'h3C, 1'b0));

        // A read held across the return to IDLE is sampled again one edge later
        @(negedge clk);
        cmd[1] = 8'h01; addr[1] = 8'h03;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = vld[1];
            if (vld[1]) chk("held_read_data", bus1, 8'h3C);
        end
        cmd[1] = 8'h00;
        chk("held_read_valid_pattern", pat, 6'b010010);
        @(negedge clk);

        // Reset during RD_WAIT
        @(negedge clk);
        cmd[0] = 8'h01; addr[0] = 8'h10;
        @(negedge clk);
        cmd[0] = 8'h00;
        chk("busy_before_reset", busy[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_wait_busy", busy[0], CLR ? 1 : 0);
        chk("reset_wait_valid", vld[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid(6, "no_valid_after_reset_wait");
        wait_idle();
        run_vec(mk(0, 8'h01, 8'h10, 8'h00, CLR ? 8'h00 : 8'hA5, 1'b0));
        run_vec(mk(0, 8'h02, 8'h10, 8'hA5, 8'h00, 1'b0));

        // Reset while the bus is being driven releases it asynchronously
        @(negedge clk);
        cmd[0] = 8'h01; addr[0] = 8'h10;
        @(negedge clk);
        cmd[0] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("valid_before_reset", vld[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_drive_valid", vld[0], 0);
        chk_release(0, "reset_drive_bus_release");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid(6, "no_valid_after_reset_drive");
        wait_idle();
        run_vec(mk(0, 8'h01, 8'h10, 8'h00, CLR ? 8'h00 : 8'hA5, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_memory_resp
`default_nettype wire

// File: doc/data_memory_resp.md
Name: data_memory_resp

Overview:
- Responder end of the CPU data-memory interface: decodes the 8-bit command/address from the CPU's memory interface and answers on the shared bidirectional 8-bit data bus.
- Holds a synchronous data RAM and sequences reads with a programmable wait.
- Owns bus turnaround: drives the data bus only during its read-response cycle and releases it at all other times.
- Instantiated beside the cpu top, wired to cmd_memory / addr_memory / data_memory.

Parameters:
- DEPTH, 256, number of 8-bit words implemented; valid addresses are 0..DEPTH-1, with DEPTH at most 256.
- RD_WAIT, 1, extra wait cycles between read-command sample and data drive; legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_memory  input  8  command from CPU: 8'h00 idle, 8'h01 read, 8'h02 write; other values are illegal.
- addr_memory  input  8  word address from CPU.
- data_memory  inout  8  shared data bus; sampled on writes, driven during the read response, otherwise 8'hzz.
- mem_busy  output  1  high whenever the FSM is not in IDLE.
- rd_valid  output  1  high exactly in the cycle(s) data_memory is driven.
- cmd_err  output  1  one-cycle pulse on an illegal command or an out-of-range address.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE, data_memory released (8'hzz) immediately;
  - mem_busy=0, rd_valid=0, cmd_err=0, wait counter=0, address/data registers=0.
  - RAM contents are not reset (but see the optional feature).
- FSM states: IDLE, RD_WAIT, RD_DRIVE (plus CLEAR when the optional feature is compiled in).
- IDLE: cmd_memory is level-sampled on every rising edge.
  - 8'h00: stay in IDLE.
  - 8'h02 write: mem[addr_memory] <= data_memory on the sampling edge; stay in IDLE; write latency is 1 edge, with no busy.
  - 8'h01 read: capture the address into addr_q.
    - If RD_WAIT=0, go to RD_DRIVE.
    - Otherwise load the counter with RD_WAIT-1 and go to RD_WAIT.
  - Any other value: cmd_err pulses high for the next cycle; no state change; RAM untouched.
- RD_WAIT: the counter decrements each edge; on the edge where the counter is 0, go to RD_DRIVE.
- RD_DRIVE entry: the output data register loads mem[addr_q] and the output enable is registered high.
  - data_memory = read data and rd_valid=1 for exactly one cycle.
  - Next edge: return to IDLE and release the bus (no overlap with the next command).
- Read latency: data valid on the bus RD_WAIT+1 edges after the sampling edge.
- One transaction outstanding at a time:
  - commands arriving in RD_WAIT or RD_DRIVE are ignored, not queued;
  - the CPU must return cmd_memory to 8'h00 or re-present the command once IDLE is reached;
  - a READ still held at the edge that returns to IDLE is not sampled on that edge, and is sampled as a new read on the following IDLE edge.
- Out-of-range address (addr_memory >= DEPTH):
  - write: ignored, cmd_err pulses;
  - read: completes with normal timing, drives 8'h00, cmd_err pulses.
- Write followed by a read of the same address returns the new data.
- Reset asserted mid-read: the bus is released asynchronously, the FSM returns to IDLE, and no data is driven after reset is released.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined:
  - after rst_n deasserts, the FSM enters CLEAR and writes 8'h00 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles);
  - mem_busy=1 throughout, and all commands are ignored with no cmd_err;
  - the FSM then enters IDLE;
  - reset during CLEAR restarts the clear from address 0.
- Undefined: the CLEAR state and its counter are absent; the FSM enters IDLE directly from reset, and RAM power-up contents are undefined.

Decomposition:
- Package dmem_pkg:
  - command codes CMD_IDLE=8'h00, CMD_READ=8'h01, CMD_WRITE=8'h02;
  - FSM state encoding;
  - counter width constant (3 bits).
- Sub-module dmem_array:
  - DEPTH x 8 RAM, one synchronous write port, one registered read port;
  - the clear-path write mux lives in the parent.
- The parent holds the FSM, address-range check, tri-state driver and error pulse.

Test Plan:
1. Reset while the bus is idle -> data_memory=8'hzz, mem_busy=0, rd_valid=0, cmd_err=0.
2. Write 8'hA5 to addr 8'h10, then read addr 8'h10 with RD_WAIT=1 -> 8'hA5 on data_memory exactly 2 edges after the read sample, rd_valid high for 1 cycle, bus 8'hzz before and after.
3. RD_WAIT=0 and RD_WAIT=7 sweep, reading addr 8'h03 holding 8'h3C -> data appears after 1 and 8 edges respectively; a write presented while mem_busy=1 is ignored (mem[target] unchanged).
4. cmd_memory=8'h07, then a write to addr 8'hF0 with DEPTH=128 -> a cmd_err pulse for each, RAM unchanged; a read of 8'hF0 drives 8'h00 with cmd_err.
5. rst_n pulsed low during RD_WAIT -> data_memory released within the same cycle, no rd_valid after release, next command accepted normally.
6. With DMEM_CLEAR_EN and DEPTH=16 -> mem_busy high for 16 cycles after reset; a read during CLEAR is ignored; a later read of any address returns 8'h00.
